// File: rtl/fwd_regfile.sv
// rtl/fwd_regfile.sv - multi-port register file with EX/MEM/WB forwarding and load-use stall
// Ports:
//   clk                 single clock, writes on rising edge
//   rst                 asynchronous active-low reset, clears storage
//   re/raddr/rdata      NUM_RD combinational read ports, port k at [k*W +: W]
//   we/waddr/wdata      writeback-stage write port (also forwarded write-through)
//   ex_*                execute-stage result in flight (ex_is_load marks a load)
//   mem_*               memory-stage result in flight
//   stall_req           freeze PC and IF/ID, bubble into ID/EX
// Config macro: FWD_REGFILE_BYPASS_EN
//   defined   - EX/MEM results are forwarded; only a load in EX causes a stall
//   undefined - EX/MEM results are never forwarded; any EX/MEM match stalls
module fwd_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     ex_wreg,
  input  logic [ADDR_W-1:0]        ex_wd,
  input  logic [DATA_W-1:0]        ex_wdata,
  input  logic                     ex_is_load,
  input  logic                     mem_wreg,
  input  logic [ADDR_W-1:0]        mem_wd,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     stall_req
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd_word [NUM_RD];
  logic [NUM_RD-1:0] port_stall;

  // Index 0 is never written, so it stays zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              active;
    logic              ex_hit;
    logic              mem_hit;
    logic              wb_hit;
    logic [DATA_W-1:0] base;

    assign ra      = raddr[k*ADDR_W +: ADDR_W];
    // A port reading index 0, disabled, or held in reset never forwards or stalls.
    assign active  = rst && re[k] && (ra != '0);
    assign ex_hit  = ex_wreg && (ex_wd == ra);
    assign mem_hit = mem_wreg && (mem_wd == ra);
    assign wb_hit  = we && (waddr == ra);
    // Write-through: a pending writeback is visible in the same cycle.
    assign base    = wb_hit ? wdata : regs[ra];

`ifdef FWD_REGFILE_BYPASS_EN
    // Youngest in-flight result wins; load data is not ready yet, so stall.
    assign port_stall[k] = active && ex_hit && ex_is_load;
    assign rd_word[k]    = !active ? '0 :
                           ex_hit  ? ex_wdata :
                           mem_hit ? mem_wdata : base;
`else
    assign port_stall[k] = active && (ex_hit || mem_hit);
    assign rd_word[k]    = active ? base : '0;
`endif
  end

`ifndef FWD_REGFILE_BYPASS_EN
  // In-flight data is only compared by index when forwarding is off.
  logic unused_nobypass;
  assign unused_nobypass = ^{ex_wdata, mem_wdata, ex_is_load};
`endif

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rdata[k*DATA_W +: DATA_W] = rd_word[k];
    end
  end

  assign stall_req = |port_stall;

endmodule
